aes_key_schedule_ctrl: RTL and testbench

- Sequencer that drives one combinational single-round AES-128 key expansion unit over rounds 1..10.
- Stores all 11 round keys (rk0..rk10) in an internal register file.
- Serves stored round keys to the cipher round datapath through a registered read port.
- Sits between the key-load interface and the round datapath.
- The expansion unit is instantiated internally: 4-bit round index in, 128-bit key in, 128-bit key out.

---
 rtl/aes_key_schedule_ctrl_if.sv | 33 +++
 rtl/aes_key_schedule_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_aes_key_schedule_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/aes_key_schedule_ctrl_if.sv
// Key-load and round-key read bundle for aes_key_schedule_ctrl.
// The stream outputs exist only when KEYSCHED_STREAM_EN is defined.
interface aes_key_schedule_ctrl_if;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
`ifdef KEYSCHED_STREAM_EN
  logic         stream_valid;
  logic [127:0] stream_key;

  modport master (
    output key_in, key_valid, rd_idx,
    input  key_ready, busy, keys_valid, rd_key, stream_valid, stream_key
  );
  modport slave (
    input  key_in, key_valid, rd_idx,
    output key_ready, busy, keys_valid, rd_key, stream_valid, stream_key
  );
`else
  modport master (
    output key_in, key_valid, rd_idx,
    input  key_ready, busy, keys_valid, rd_key
  );
  modport slave (
    input  key_in, key_valid, rd_idx,
    output key_ready, busy, keys_valid, rd_key
  );
`endif
endinterface

// File: rtl/aes_key_schedule_ctrl.sv
// AES-128 key schedule sequencer: expands rk0..rk10 one round per cycle and serves them on a registered read port.
// Optional KEYSCHED_STREAM_EN adds a stream of each key as it is written.
module aes_key_expand_round (
  input  logic [3:0]   round_i,
  input  logic [127:0] key_i,
  output logic [127:0] key_o
);
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254, 0 maps to 0) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240, x254, inv;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x254 = gf_mul(gf_mul(x240, x12), x2);
    inv  = x254;
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  logic [7:0]  rcon;
  logic [31:0] rot_w, sub_w, t_w;
  logic [31:0] w4, w5, w6, w7;

  always_comb begin
    rcon = 8'h00;
    case (round_i)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
    rot_w = {key_i[23:0], key_i[31:24]};
    sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]), sbox(rot_w[15:8]), sbox(rot_w[7:0])};
    t_w   = sub_w ^ {rcon, 24'h000000};
    w4    = key_i[127:96] ^ t_w;
    w5    = key_i[95:64]  ^ w4;
    w6    = key_i[63:32]  ^ w5;
    w7    = key_i[31:0]   ^ w6;
    key_o = {w4, w5, w6, w7};
  end
endmodule

module aes_key_schedule_ctrl #(
  parameter int NUM_ROUNDS = 10,
  parameter int IDX_W      = 4
) (
  input logic                    clk,
  input logic                    rst,
  aes_key_schedule_ctrl_if.slave ks
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ROUNDS);

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   cnt_q, cnt_d;
  logic               key_ready_q, key_ready_d;
  logic [127:0]       rd_key_q, rd_key_d;
  logic [127:0]       rk_q [0:NUM_ROUNDS];
  logic               accept;
  logic [IDX_W-1:0]   prev_idx;
  logic [127:0]       exp_in, exp_out;

  assign accept   = ks.key_valid && key_ready_q;
  assign prev_idx = cnt_q - 1'b1;
  assign exp_in   = (cnt_q != '0) ? rk_q[prev_idx] : '0;

  aes_key_expand_round u_round (
    .round_i (cnt_q),
    .key_i   (exp_in),
    .key_o   (exp_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = S_EXPAND;
          cnt_d   = IDX_W'(1);
        end
      end
      S_EXPAND: begin
        if (cnt_q == LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // ready is registered so it stays low for the first cycle out of reset
    key_ready_d = (state_d != S_EXPAND);
    rd_key_d    = (ks.rd_idx <= LAST) ? rk_q[ks.rd_idx] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      key_ready_q <= 1'b0;
      rd_key_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      key_ready_q <= key_ready_d;
      rd_key_q    <= rd_key_d;
    end
  end

  // Round key storage is deliberately not reset; keys_valid qualifies it
  always_ff @(posedge clk) begin
    if (accept) begin
      rk_q[0] <= ks.key_in;
    end else if (state_q == S_EXPAND) begin
      rk_q[cnt_q] <= exp_out;
    end
  end

  assign ks.key_ready  = key_ready_q;
  assign ks.busy       = (state_q == S_EXPAND);
  assign ks.keys_valid = (state_q == S_DONE);
  assign ks.rd_key     = rd_key_q;

`ifdef KEYSCHED_STREAM_EN
  logic         stream_valid_q, stream_valid_d;
  logic [127:0] stream_key_q, stream_key_d;

  always_comb begin
    stream_valid_d = 1'b0;
    stream_key_d   = stream_key_q;
    if (accept) begin
      stream_valid_d = 1'b1;
      stream_key_d   = ks.key_in;
    end else if (state_q == S_EXPAND) begin
      stream_valid_d = 1'b1;
      stream_key_d   = exp_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stream_valid_q <= 1'b0;
      stream_key_q   <= '0;
    end else begin
      stream_valid_q <= stream_valid_d;
      stream_key_q   <= stream_key_d;
    end
  end

  assign ks.stream_valid = stream_valid_q;
  assign ks.stream_key   = stream_key_q;
`endif
endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Directed bench for aes_key_schedule_ctrl using FIPS-197 key schedule vectors.
module tb_aes_key_schedule_ctrl;
  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   cyc;

  aes_key_schedule_ctrl_if ks ();

  aes_key_schedule_ctrl dut (
    .clk (clk),
    .rst (rst),
    .ks  (ks)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B_RK1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] B_RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic [127:0] a_rk [0:10];

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents a key for one edge; returns at the falling edge after the accept edge
  task automatic accept_key(input logic [127:0] k, input bit hold_other, input logic [127:0] other);
    @(negedge clk);
    ks.key_in    = k;
    ks.key_valid = 1'b1;
    @(negedge clk);
    if (hold_other) ks.key_in = other;
    else            ks.key_valid = 1'b0;
    check("busy_after_accept", ks.busy, 1'b1);
    check("kv_drop_after_accept", ks.keys_valid, 1'b0);
  endtask

  // cyc counts edges from the accept edge (inclusive) to the one that raises keys_valid
  task automatic wait_keys(input bit hold_other);
    cyc = 1;
    while (!ks.keys_valid && cyc < 60) begin
      if (hold_other) check("ready_low_expand", ks.key_ready, 1'b0);
      @(negedge clk);
      cyc++;
    end
    ks.key_valid = 1'b0;
    check("keys_valid_latency", 128'(cyc), 128'd11);
  endtask

  task automatic read_key(input string tag, input logic [3:0] idx, input logic [127:0] exp);
    @(negedge clk);
    ks.rd_idx = idx;
    @(negedge clk);
    check(tag, ks.rd_key, exp);
  endtask

  initial begin
    a_rk[0]  = KEY_A;
    a_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    a_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    a_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    a_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    a_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    a_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    a_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    a_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    a_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    a_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    n_tests      = 0;
    n_fail       = 0;
    rst          = 1'b1;
    ks.key_in    = '0;
    ks.key_valid = 1'b0;
    ks.rd_idx    = '0;
    repeat (3) @(negedge clk);
    check("rst_key_ready", ks.key_ready, 1'b0);
    check("rst_busy", ks.busy, 1'b0);
    check("rst_keys_valid", ks.keys_valid, 1'b0);
    check("rst_rd_key", ks.rd_key, '0);
    rst = 1'b0;
    check("ready_before_edge", ks.key_ready, 1'b0);
    @(negedge clk);
    check("ready_after_rst", ks.key_ready, 1'b1);

    // FIPS-197 key
    accept_key(KEY_A, 1'b0, '0);
    check("ready_low_in_expand", ks.key_ready, 1'b0);
    wait_keys(1'b0);
    check("busy_done", ks.busy, 1'b0);
    check("ready_done", ks.key_ready, 1'b1);
    read_key("a_rk1", 4'd1, a_rk[1]);
    read_key("a_rk10", 4'd10, a_rk[10]);
    read_key("a_rk5", 4'd5, a_rk[5]);
    read_key("a_rk0", 4'd0, a_rk[0]);

    // New key in DONE; rd_idx=0 on the write edge still sees the old rk0
    accept_key(KEY_B, 1'b0, '0);
    check("rd_same_edge_old", ks.rd_key, KEY_A);
    wait_keys(1'b0);
    read_key("b_rk1", 4'd1, B_RK1);
    read_key("b_rk10", 4'd10, B_RK10);

    // key_valid held with a different key during expansion
    accept_key(KEY_A, 1'b1, KEY_B);
    wait_keys(1'b1);
    @(negedge clk);
    check("no_reaccept", ks.keys_valid, 1'b1);
    read_key("hold_rk1", 4'd1, a_rk[1]);
    read_key("hold_rk10", 4'd10, a_rk[10]);
    read_key("rd_idx11", 4'd11, '0);
    read_key("rd_idx15", 4'd15, '0);
    read_key("rd_idx0", 4'd0, KEY_A);

`ifdef KEYSCHED_STREAM_EN
    accept_key(KEY_A, 1'b0, '0);
    for (int i = 0; i < 11; i++) begin
      check("stream_valid", ks.stream_valid, 1'b1);
      check("stream_key", ks.stream_key, a_rk[i]);
      @(negedge clk);
    end
    check("stream_valid_end", ks.stream_valid, 1'b0);
    check("stream_kv", ks.keys_valid, 1'b1);
`endif

    // Asynchronous reset in the middle of expansion
    accept_key(KEY_B, 1'b0, '0);
    repeat (4) @(negedge clk);
    check("busy_before_rst", ks.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", ks.busy, 1'b0);
    check("arst_ready", ks.key_ready, 1'b0);
    check("arst_keys_valid", ks.keys_valid, 1'b0);
    check("arst_rd_key", ks.rd_key, '0);
`ifdef KEYSCHED_STREAM_EN
    check("arst_stream_valid", ks.stream_valid, 1'b0);
    check("arst_stream_key", ks.stream_key, '0);
`endif
    repeat (2) @(negedge clk);
    check("arst_kv_hold", ks.keys_valid, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("kv_after_arst", ks.keys_valid, 1'b0);
    check("ready_after_arst", ks.key_ready, 1'b1);
    accept_key(KEY_B, 1'b0, '0);
    wait_keys(1'b0);
    read_key("post_rst_rk1", 4'd1, B_RK1);
    read_key("post_rst_rk10", 4'd10, B_RK10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
